// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx_scheduler
//  Purpose  : Aligns OV7670 capture to frame boundaries, keeps luminance
//             bytes, buffers them in a small FIFO and hands them to the UART
//             transmitter through a dtr/ready handshake. Supports single-shot
//             and continuous capture with frame decimation.
//  Options  : FRAME_HEADER_EN - prefix each frame with 0xFF,0x00 and remap
//             luminance 0xFF to 0xFE so the marker stays unique.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_tx_scheduler #(
  parameter int FIFO_AW     = 4,
  parameter int SKIP_FRAMES = 0,
  parameter int GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PCLK,
  input  logic       Href,
  input  logic       VSYNC,
  input  logic [7:0] in_pixel,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       ready,
  output logic       dtr,
  output logic [7:0] data,
  output logic       busy,
  output logic       overflow,
  output logic [9:0] line_cnt,
  output logic [7:0] frame_cnt
);

  localparam int        c_DEPTH = 1 << FIFO_AW;
  localparam int        c_GW    = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [3:0] c_SKIP = 4'(SKIP_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
`ifdef FRAME_HEADER_EN
    S_HEADER  = 3'd4,
`endif
    S_DRAIN   = 3'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_pclk_sync;
  logic [2:0]          r_href_sync;
  logic [2:0]          r_vsync_sync;
  logic                r_parity;
  logic [7:0]          r_mem [c_DEPTH];
  logic [FIFO_AW:0]    r_wptr;
  logic [FIFO_AW:0]    r_rptr;
  logic [c_GW-1:0]     r_guard;
  logic                r_cont;
  logic                r_stop_seen;
  logic                r_vs_seen;
  logic [3:0]          r_skip;
`ifdef FRAME_HEADER_EN
  logic                r_hdr_idx;
`endif

  // Index 1 is the synchronized level, index 2 its previous value.
  logic w_pclk_rise;
  logic w_href;
  logic w_href_rise;
  logic w_vsync;
  logic w_vsync_rise;
  logic w_pix_strobe;
  logic w_luma_valid;
  logic [7:0] w_luma_byte;
  logic w_wr_req;
  logic w_empty;
  logic w_full;
  logic w_hdr_pend;
  logic [7:0] w_hdr_byte;
  logic w_issue;
  logic w_rd;
  logic w_wr;
  logic w_ovf_evt;

  assign w_pclk_rise  = r_pclk_sync[1] & ~r_pclk_sync[2];
  assign w_href       = r_href_sync[1];
  assign w_href_rise  = r_href_sync[1] & ~r_href_sync[2];
  assign w_vsync      = r_vsync_sync[1];
  assign w_vsync_rise = r_vsync_sync[1] & ~r_vsync_sync[2];

  // Camera activity during VSYNC high is blanking and is ignored entirely.
  assign w_pix_strobe = w_pclk_rise & w_href & ~w_vsync;
  assign w_luma_valid = w_pix_strobe & ~r_parity;

`ifdef FRAME_HEADER_EN
  assign w_luma_byte = (in_pixel == 8'hFF) ? 8'hFE : in_pixel;
  assign w_hdr_pend  = (r_state == S_HEADER);
  assign w_hdr_byte  = r_hdr_idx ? 8'h00 : 8'hFF;
`else
  assign w_luma_byte = in_pixel;
  assign w_hdr_pend  = 1'b0;
  assign w_hdr_byte  = 8'h00;
`endif

  assign w_wr_req  = w_luma_valid & (r_state == S_CAPTURE);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_issue   = (w_hdr_pend | ~w_empty) & ready & (r_guard == '0);
  // Header bytes take precedence; the FIFO is only popped for pixel bytes.
  assign w_rd      = w_issue & ~w_hdr_pend;
  assign w_wr      = w_wr_req & (~w_full | w_rd);
  assign w_ovf_evt = w_wr_req & w_full & ~w_rd;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_sync  <= '0;
      r_href_sync  <= '0;
      r_vsync_sync <= '0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[1:0], PCLK};
      r_href_sync  <= {r_href_sync[1:0], Href};
      r_vsync_sync <= {r_vsync_sync[1:0], VSYNC};
    end
  end

  // Byte parity within a line: even bytes are luminance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (!w_href) begin
      r_parity <= 1'b0;
    end else if (w_pix_strobe) begin
      r_parity <= ~r_parity;
    end
  end

  // FIFO storage; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= w_luma_byte;
    end
  end

  // FIFO pointers with one extra wrap bit to distinguish full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Transmit strobe, data hold register and post-strobe guard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtr     <= 1'b0;
      data    <= 8'h00;
      r_guard <= '0;
    end else if (w_issue) begin
      dtr     <= 1'b1;
      data    <= w_hdr_pend ? w_hdr_byte : r_mem[r_rptr[FIFO_AW-1:0]];
      r_guard <= c_GW'(GUARD);
    end else begin
      dtr <= 1'b0;
      if (r_guard != '0) r_guard <= r_guard - c_GW'(1);
    end
  end

  // Capture sequencing FSM with its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      r_cont      <= 1'b0;
      r_stop_seen <= 1'b0;
      r_vs_seen   <= 1'b0;
      r_skip      <= '0;
`ifdef FRAME_HEADER_EN
      r_hdr_idx   <= 1'b0;
`endif
    end else begin
      if (w_ovf_evt) overflow <= 1'b1;
      if (stop && (r_state != S_IDLE)) r_stop_seen <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_stop_seen <= 1'b0;
          if (start) begin
            r_state   <= S_ARM;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            line_cnt  <= '0;
            r_cont    <= cont;
            r_vs_seen <= 1'b0;
          end
        end

        S_ARM: begin
          if (w_vsync) begin
            r_vs_seen <= 1'b1;
          end else if (r_vs_seen) begin
            // VSYNC has fallen: a new frame begins.
            r_vs_seen <= 1'b0;
            if (r_skip != 4'd0) begin
              r_skip <= r_skip - 4'd1;
            end else begin
              line_cnt <= '0;
`ifdef FRAME_HEADER_EN
              r_state   <= S_HEADER;
              r_hdr_idx <= 1'b0;
`else
              r_state  <= S_CAPTURE;
`endif
            end
          end
        end

`ifdef FRAME_HEADER_EN
        S_HEADER: begin
          if (w_issue) begin
            if (r_hdr_idx) r_state <= S_CAPTURE;
            else           r_hdr_idx <= 1'b1;
          end
        end
`endif

        S_CAPTURE: begin
          if (w_vsync_rise) begin
            r_state <= S_DRAIN;
          end else if (w_href_rise && !w_vsync && (line_cnt != 10'd1023)) begin
            line_cnt <= line_cnt + 10'd1;
          end
        end

        S_DRAIN: begin
          if (w_empty && (r_guard == '0)) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (r_cont && !r_stop_seen && !stop) begin
              r_state   <= S_ARM;
              r_skip    <= c_SKIP;
              r_vs_seen <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
